// File: rtl/sort_pkg.sv
// Shared constants and fill-state encoding for the four-element sorting unit.
package sort_pkg;

  localparam int SORT_NELEMS    = 4;
  localparam int SORT_IDX_NBITS = 2;

  typedef enum logic [SORT_IDX_NBITS-1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    FILL2 = 2'd2,
    FILL3 = 2'd3
  } fill_state_e;

endpackage

// File: rtl/sort_deserializer_if.sv
// Element stream in (val/rdy) and 4-wide bundle out (val only) for sort_deserializer.
// SORT_DESERIALIZER_PAD_EN adds in_last for short, padded bundles.
interface sort_deserializer_if #(
  parameter int p_nbits = 1
);

  logic               in_val;
  logic               in_rdy;
  logic [p_nbits-1:0] in_msg;
`ifdef SORT_DESERIALIZER_PAD_EN
  logic               in_last;
`endif
  logic               out_val;
  logic [p_nbits-1:0] out0;
  logic [p_nbits-1:0] out1;
  logic [p_nbits-1:0] out2;
  logic [p_nbits-1:0] out3;

`ifdef SORT_DESERIALIZER_PAD_EN
  modport master (output in_val, in_msg, in_last,
                  input  in_rdy, out_val, out0, out1, out2, out3);
  modport slave  (input  in_val, in_msg, in_last,
                  output in_rdy, out_val, out0, out1, out2, out3);
`else
  modport master (output in_val, in_msg,
                  input  in_rdy, out_val, out0, out1, out2, out3);
  modport slave  (input  in_val, in_msg,
                  output in_rdy, out_val, out0, out1, out2, out3);
`endif

endinterface

// File: rtl/sort_deserializer_ctrl.sv
// Fill counter, slot write decode and bundle-valid pulse for sort_deserializer.
// SORT_DESERIALIZER_PAD_EN adds in_last and the pad-mask generation.
module sort_deserializer_ctrl
  import sort_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_val,
`ifdef SORT_DESERIALIZER_PAD_EN
  input  logic                   in_last,
`endif
  output logic                   in_rdy,
  output logic [SORT_NELEMS-1:0] slot_we,
  output logic [SORT_NELEMS-1:0] pad_mask,
  output logic                   out_load,
  output logic                   out_val
);

  fill_state_e cnt_q, cnt_d;
  logic        out_val_q;
  logic        accept;
  logic        last;

  assign in_rdy = !reset;
  assign accept = in_val && in_rdy;

`ifdef SORT_DESERIALIZER_PAD_EN
  assign last = in_last;
`else
  assign last = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= FILL0;
      out_val_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      out_val_q <= out_load;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = (cnt_q == FILL3 || last) ? FILL0 : fill_state_e'(cnt_q + 2'd1);
    end
  end

  // A short bundle pads every lane above the one being written.
  always_comb begin
    slot_we  = '0;
    pad_mask = '0;
    out_load = accept && (cnt_q == FILL3 || last);
    for (int j = 0; j < SORT_NELEMS; j++) begin
      slot_we[j]  = accept && (int'(cnt_q) == j);
      pad_mask[j] = accept && last && (j > int'(cnt_q));
    end
  end

  assign out_val = out_val_q;

  a_in_val_known: assert property (@(posedge clk) disable iff (reset) !$isunknown(in_val));
  a_out_val_known: assert property (@(posedge clk) disable iff (reset) !$isunknown(out_val));

endmodule

// File: rtl/sort_deserializer.sv
// Gathers four consecutive stream elements into a one-cycle bundle for the sort unit.
// SORT_DESERIALIZER_PAD_EN enables in_last to flush a short bundle padded with all-ones.
module sort_deserializer
  import sort_pkg::*;
#(
  parameter int p_nbits = 1
) (
  input  logic               clk,
  input  logic               reset,
  sort_deserializer_if.slave bus
);

  logic [SORT_NELEMS-1:0] slot_we;
  logic [SORT_NELEMS-1:0] pad_mask;
  logic                   out_load;
  logic                   out_val;

  logic [p_nbits-1:0] slot_q [SORT_NELEMS-1];
  logic [p_nbits-1:0] held   [SORT_NELEMS];
  logic [p_nbits-1:0] out_d  [SORT_NELEMS];
  logic [p_nbits-1:0] out_q  [SORT_NELEMS];

  sort_deserializer_ctrl u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .in_val   (bus.in_val),
`ifdef SORT_DESERIALIZER_PAD_EN
    .in_last  (bus.in_last),
`endif
    .in_rdy   (bus.in_rdy),
    .slot_we  (slot_we),
    .pad_mask (pad_mask),
    .out_load (out_load),
    .out_val  (out_val)
  );

  // The last lane is written straight from in_msg, so only three slots need storage.
  // NOTE: slots carry no reset; their contents are don't-care until written.
  always_ff @(posedge clk) begin
    for (int j = 0; j < SORT_NELEMS - 1; j++) begin
      if (slot_we[j]) slot_q[j] <= bus.in_msg;
    end
  end

  always_comb begin
    for (int j = 0; j < SORT_NELEMS - 1; j++) held[j] = slot_q[j];
    held[SORT_NELEMS-1] = '1;
  end

  always_comb begin
    for (int j = 0; j < SORT_NELEMS; j++) begin
      out_d[j] = slot_we[j] ? bus.in_msg : (pad_mask[j] ? {p_nbits{1'b1}} : held[j]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '{default: '0};
    end else if (out_load) begin
      out_q <= out_d;
    end
  end

  assign bus.out_val = out_val;
  assign bus.out0    = out_q[0] & {p_nbits{out_val}};
  assign bus.out1    = out_q[1] & {p_nbits{out_val}};
  assign bus.out2    = out_q[2] & {p_nbits{out_val}};
  assign bus.out3    = out_q[3] & {p_nbits{out_val}};

endmodule

// File: tb/tb_sort_deserializer.sv
// Directed bench for sort_deserializer (p_nbits=8); SORT_DESERIALIZER_PAD_EN adds padded-bundle sequences.
module tb_sort_deserializer;

  localparam int NB = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sort_deserializer_if #(.p_nbits(NB)) bus ();

  sort_deserializer #(.p_nbits(NB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic        rst;
    logic        val;
    logic [7:0]  msg;
    logic        rdy;
    logic        oval;
    logic [31:0] outs;   // {out0, out1, out2, out3}
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic val, input logic [7:0] msg,
                     input logic rdy, input logic oval, input logic [31:0] outs);
    vec_t t;
    t.rst  = rst;
    t.val  = val;
    t.msg  = msg;
    t.rdy  = rdy;
    t.oval = oval;
    t.outs = outs;
    vecs.push_back(t);
  endtask

  function automatic logic [31:0] bundle();
    return {bus.out0, bus.out1, bus.out2, bus.out3};
  endfunction

  task automatic send(input logic [7:0] m);
    @(negedge clk);
    reset      = 1'b0;
    bus.in_val = 1'b1;
    bus.in_msg = m;
`ifdef SORT_DESERIALIZER_PAD_EN
    bus.in_last = 1'b0;
`endif
  endtask

`ifdef SORT_DESERIALIZER_PAD_EN
  task automatic send_last(input logic [7:0] m);
    @(negedge clk);
    reset       = 1'b0;
    bus.in_val  = 1'b1;
    bus.in_msg  = m;
    bus.in_last = 1'b1;
  endtask
`endif

  // Idles the stream and waits a bounded number of cycles for the bundle pulse.
  task automatic expect_bundle(input string name, input logic [31:0] exp);
    int lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      bus.in_val = 1'b0;
`ifdef SORT_DESERIALIZER_PAD_EN
      bus.in_last = 1'b0;
`endif
      #1;
      if (bus.out_val === 1'b1) lat = c;
    end
    check({name, " latency"}, lat, 1);
    check({name, " bundle"}, bundle(), exp);
    @(negedge clk);
    #1;
    check({name, " pulse end"}, {31'd0, bus.out_val}, 32'd0);
    check({name, " masked"}, bundle(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    bus.in_val = 1'b0;
    bus.in_msg = '0;
`ifdef SORT_DESERIALIZER_PAD_EN
    bus.in_last = 1'b0;
`endif
    repeat (2) @(posedge clk);

    // rst val msg rdy oval {out0..out3}; outputs are those visible before the row's edge
    add(1, 0, 8'h00, 0, 0, 32'h0);
    add(0, 1, 8'h04, 1, 0, 32'h0);
    add(0, 1, 8'h03, 1, 0, 32'h0);
    add(0, 1, 8'h02, 1, 0, 32'h0);
    add(0, 1, 8'h01, 1, 0, 32'h0);
    add(0, 0, 8'h00, 1, 1, 32'h04030201);
    add(0, 0, 8'h00, 1, 0, 32'h0);
    add(0, 1, 8'h10, 1, 0, 32'h0);
    add(0, 1, 8'h11, 1, 0, 32'h0);
    add(0, 1, 8'h12, 1, 0, 32'h0);
    add(0, 1, 8'h13, 1, 0, 32'h0);
    add(0, 1, 8'h14, 1, 1, 32'h10111213);
    add(0, 1, 8'h15, 1, 0, 32'h0);
    add(0, 1, 8'h16, 1, 0, 32'h0);
    add(0, 1, 8'h17, 1, 0, 32'h0);
    add(0, 0, 8'h00, 1, 1, 32'h14151617);
    add(0, 0, 8'h00, 1, 0, 32'h0);
    add(0, 1, 8'h0a, 1, 0, 32'h0);
    add(0, 1, 8'h0b, 1, 0, 32'h0);
    add(0, 0, 8'h77, 1, 0, 32'h0);
    add(0, 0, 8'h78, 1, 0, 32'h0);
    add(0, 0, 8'h79, 1, 0, 32'h0);
    add(0, 1, 8'h0c, 1, 0, 32'h0);
    add(0, 1, 8'h0d, 1, 0, 32'h0);
    add(0, 0, 8'h00, 1, 1, 32'h0a0b0c0d);
    add(0, 0, 8'h00, 1, 0, 32'h0);
    add(0, 1, 8'h21, 1, 0, 32'h0);
    add(0, 1, 8'h22, 1, 0, 32'h0);
    add(0, 1, 8'h23, 1, 0, 32'h0);
    add(1, 1, 8'h99, 0, 0, 32'h0);
    add(0, 1, 8'h31, 1, 0, 32'h0);
    add(0, 1, 8'h32, 1, 0, 32'h0);
    add(0, 1, 8'h33, 1, 0, 32'h0);
    add(0, 1, 8'h34, 1, 0, 32'h0);
    add(0, 0, 8'h00, 1, 1, 32'h31323334);
    add(0, 0, 8'h00, 1, 0, 32'h0);
    add(0, 1, 8'h41, 1, 0, 32'h0);
    for (int k = 0; k < 5; k++) add(0, 0, 8'hxx, 1, 0, 32'h0);
    add(0, 1, 8'h42, 1, 0, 32'h0);
    add(0, 1, 8'h43, 1, 0, 32'h0);
    add(0, 1, 8'h44, 1, 0, 32'h0);
    add(0, 0, 8'h00, 1, 1, 32'h41424344);
    add(0, 0, 8'h00, 1, 0, 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset      = vecs[i].rst;
      bus.in_val = vecs[i].val;
      bus.in_msg = vecs[i].msg;
      #1;
      check($sformatf("row%0d in_rdy", i), {31'd0, bus.in_rdy}, {31'd0, vecs[i].rdy});
      check($sformatf("row%0d out_val", i), {31'd0, bus.out_val}, {31'd0, vecs[i].oval});
      check($sformatf("row%0d bundle", i), bundle(), vecs[i].outs);
    end

    // Long reset with in_val held high: nothing accepted, then a clean bundle from slot 0.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      reset      = 1'b1;
      bus.in_val = 1'b1;
      bus.in_msg = 8'h55;
      #1;
      check($sformatf("hold_rst%0d in_rdy", k), {31'd0, bus.in_rdy}, 32'd0);
      check($sformatf("hold_rst%0d out_val", k), {31'd0, bus.out_val}, 32'd0);
    end
    send(8'h61);
    send(8'h62);
    send(8'h63);
    send(8'h64);
    expect_bundle("after_rst", 32'h61626364);

`ifdef SORT_DESERIALIZER_PAD_EN
    send(8'h05);
    send_last(8'h06);
    expect_bundle("pad_k1", 32'h0506ffff);
    send(8'h07);
    send(8'h08);
    send(8'h09);
    send(8'h0a);
    expect_bundle("pad_follow", 32'h0708090a);
    send_last(8'h0b);
    expect_bundle("pad_k0", 32'h0bffffff);
    send(8'h0c);
    send(8'h0d);
    send_last(8'h0e);
    expect_bundle("pad_k2", 32'h0c0d0eff);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send_last(8'h04);
    expect_bundle("pad_k3", 32'h01020304);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sort_deserializer.md
Name: sort_deserializer

Overview:
- Serial-to-parallel front end for the four-element sorting unit.
- Accepts one element per cycle on a val/rdy stream and gathers four consecutive elements into a bundle.
- Presents each bundle for exactly one cycle on the val-only 4-wide interface that the sort unit consumes.
- Sits directly upstream of the sorting unit, so a narrow element stream (memory, source, or network) can feed it.

Parameters:
- p_nbits, 1, element width in bits; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_val  input  1  an input element is offered this cycle.
- in_rdy  output  1  deserializer can accept an element this cycle.
- in_msg  input  p_nbits  element value.
- out_val  output  1  bundle valid; one-cycle pulse; no backpressure.
- out0  output  p_nbits  first-accepted element of the bundle.
- out1  output  p_nbits  second-accepted element.
- out2  output  p_nbits  third-accepted element.
- out3  output  p_nbits  fourth-accepted element.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Transfer: an element is accepted when in_val && in_rdy at a rising edge.
- in_rdy = !reset, so it is combinationally 1 whenever reset is low. Output has no backpressure, so input never stalls otherwise.
- State: 2-bit fill counter cnt, acting as four states FILL0..FILL3. Also four p_nbits slot registers, an out_val register, and four output registers.
- FILLk on accept:
  - Write in_msg into slot k.
  - For k<3, go to FILL(k+1).
  - At FILL3, copy slots 0-2 plus in_msg into the output registers, set out_val=1 for the next cycle, and wrap cnt to 0 (FILL0).
- No accept: cnt and slots hold; out_val is 0 next cycle.
- Latency: out_val rises the cycle after the 4th element is accepted.
- Back-to-back: a new bundle may begin filling in the same cycle out_val is high. Output registers change only on a FILL3 accept.
- Throughput: at best one bundle every 4 cycles, which matches the sort unit's one-bundle-per-cycle capacity with margin.
- Output masking: out0..out3 are driven as register value AND {p_nbits{out_val}}, so they read 0 whenever out_val is 0.
- Reset values:
  - out_val=0, out0..out3=0 (by masking), cnt=0, in_rdy=0 during reset.
  - Slot contents after reset are don't-care.
- Reset mid-fill: a partially collected bundle is discarded and no out_val is produced for it. The first accept after reset lands in slot 0.
- in_val low with stale in_msg (including X): no state change.
- Assertions (non-synthesis): in_val and out_val are never X when reset is low.

Optional Feature:
- Macro: SORT_DESERIALIZER_PAD_EN.
- When defined, adds input port in_last (1 bit), sampled only on accept.
- Accept with in_last=1 in FILLk:
  - Emit the bundle next cycle.
  - Slots 0..k hold the accepted elements; slots k+1..3 are filled with all-ones (max value, so padding sorts last).
  - cnt returns to FILL0.
- in_last=1 in FILL3 behaves identically to a normal FILL3 accept.
- When not defined: no in_last port, and bundles are emitted only after exactly four accepts.

Decomposition:
- Shared package sort_pkg holds:
  - constant SORT_NELEMS = 4
  - constant SORT_IDX_NBITS = 2
  - typedef of the fill-state encoding (FILL0..FILL3)
- One natural sub-module: sort_deserializer_ctrl. It owns cnt, the next-state logic, the slot write-enable decode, the out_val register and (with PAD) the pad-mask generation.
- The top level holds the slot and output datapath registers.

Test Plan (p_nbits=8):
- Reset, then accept 04,03,02,01 on consecutive cycles -> out_val=1 one cycle after the 01 accept, with {out0..out3}={04,03,02,01}; out_val=0 the following cycle, outputs read 00.
- Eight consecutive accepts 10..17 -> two out_val pulses 4 cycles apart, carrying {10,11,12,13} then {14,15,16,17}.
- Accepts 0a,0b, then in_val low 3 cycles, then 0c,0d -> single bundle {0a,0b,0c,0d}; no out_val during the gap.
- Accept 21,22,23, assert reset 1 cycle, then accept 31,32,33,34 -> no bundle for 21..23; next bundle {31,32,33,34}; in_rdy=0 during reset.
- in_val low with in_msg=X for 5 cycles -> cnt unchanged, out_val=0, no assertion failure.
- PAD_EN: accept 05, then 06 with in_last=1 -> next cycle bundle {05,06,ff,ff}; following accepts start at slot 0.
